// File: rtl/seq_magnitude_comparator_if.sv
// Operand/handshake bundle for seq_magnitude_comparator; the master drives operands and start, the slave returns status and result.
interface seq_magnitude_comparator_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             l;
  logic             g;
  logic             q;
  logic             busy;
  logic             done;
  logic             lt;
  logic             gt;
  logic             eq;

  modport master (
    output start, a, b, signed_mode, l, g, q,
    input  busy, done, lt, gt, eq
  );

  modport slave (
    input  start, a, b, signed_mode, l, g, q,
    output busy, done, lt, gt, eq
  );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits/cycle; done NUM+1 cycles after start (earlier with SEQ_CMP_EARLY_EXIT_EN).
// No backpressure: start is ignored while busy; lt/gt/eq hold until the next done.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  seq_magnitude_comparator_if.slave  bus
);
  localparam int NUM  = WIDTH / DIGIT;
  localparam int IDXW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              dec_q, dec_d, dlt_q, dlt_d;
  logic              l_q, l_d, g_q, g_d;
  logic              done_q, done_d;
  logic              lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;

  logic [DIGIT-1:0]  a_dig, b_dig;
  logic              dig_ne, dig_lt, cur_dec, cur_lt, last;
  logic              unused_q;

  // Operands shift left each step, so the digit under test is always the top one.
  assign a_dig   = a_q[WIDTH-1 -: DIGIT];
  assign b_dig   = b_q[WIDTH-1 -: DIGIT];
  assign dig_ne  = (a_dig != b_dig);
  assign dig_lt  = (a_dig < b_dig);
  assign cur_dec = dec_q | dig_ne;
  assign cur_lt  = dec_q ? dlt_q : dig_lt;

`ifdef SEQ_CMP_EARLY_EXIT_EN
  assign last = (idx_q == '0) || dig_ne;
`else
  assign last = (idx_q == '0);
`endif

  // The equal cascade bit never affects the outcome: a full tie without g/l reports eq.
  assign unused_q = bus.q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    dec_d   = dec_q;
    dlt_d   = dlt_q;
    l_d     = l_q;
    g_d     = g_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.signed_mode ? (bus.a ^ MSB_MASK) : bus.a;
          b_d     = bus.signed_mode ? (bus.b ^ MSB_MASK) : bus.b;
          idx_d   = IDXW'(NUM - 1);
          dec_d   = 1'b0;
          dlt_d   = 1'b0;
          l_d     = bus.l;
          g_d     = bus.g;
        end
      end
      RUN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        idx_d = idx_q - IDXW'(1);
        dec_d = cur_dec;
        dlt_d = cur_lt;
        if (last) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (cur_dec) begin
            lt_d = cur_lt;
            gt_d = ~cur_lt;
            eq_d = 1'b0;
          end else begin
            gt_d = g_q;
            lt_d = ~g_q & l_q;
            eq_d = ~g_q & ~l_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      dec_q   <= 1'b0;
      dlt_q   <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      dec_q   <= dec_d;
      dlt_q   <= dlt_d;
      l_q     <= l_d;
      g_q     <= g_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.lt   = lt_q;
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
endmodule
